// File: rtl/_mul32.sv
// _mul32: sequential shift-and-add multiplier returning the low 32 bits of a*b
// (RV32 MUL semantics). One iteration per clock in RUN; the only adder is
// ripple_add32.
//
// Compile-time option:
//   MUL32_EARLY_EN - when defined, RUN also ends after any iteration that leaves
//                    the shifted multiplier at zero. The result is unchanged;
//                    only the latency gets shorter for small multipliers.
//
// Handshake: in IDLE, start=1 at a rising edge is accepted and a/b are captured.
// busy is high for every RUN cycle. done pulses for exactly one cycle (DONE)
// and p is valid from that cycle until the next result is loaded. start is
// ignored outside IDLE.

// 32-bit ripple-carry adder, carry-in 0, carry-out dropped.
module ripple_add32 (
    input  logic [31:0] x,
    input  logic [31:0] y,
    output logic [31:0] s
);
    logic [31:0] c;

    assign c[0] = 1'b0;

    for (genvar i = 0; i < 32; i++) begin : g_bit
        assign s[i] = x[i] ^ y[i] ^ c[i];
        if (i < 31) begin : g_carry
            assign c[i+1] = (x[i] & y[i]) | (c[i] & (x[i] ^ y[i]));
        end
    end
endmodule

module _mul32 (
    input  logic        clk,
    input  logic        rst_n,
    input  logic        start,
    input  logic [31:0] a,
    input  logic [31:0] b,
    output logic        busy,
    output logic        done,
    output logic [31:0] p
);
    typedef enum logic [1:0] {
        S_IDLE = 2'd0,
        S_RUN  = 2'd1,
        S_DONE = 2'd2
    } state_t;

    state_t      state;
    state_t      state_nxt;
    logic [31:0] mcand;
    logic [31:0] mplier;
    logic [31:0] acc;
    logic [31:0] sum;
    logic [31:0] acc_nxt;
    logic [4:0]  cnt;
    logic        last_iter;

    ripple_add32 u_add (
        .x (acc),
        .y (mcand),
        .s (sum)
    );

    // Accumulator value produced by the current RUN iteration.
    always_comb begin
        acc_nxt = mplier[0] ? sum : acc;
    end

    // Decide whether the current RUN iteration is the final one.
    always_comb begin
`ifdef MUL32_EARLY_EN
        // mplier[31:1] is the multiplier after this iteration's shift.
        last_iter = (cnt == 5'd31) || (mplier[31:1] == 31'd0);
`else
        last_iter = (cnt == 5'd31);
`endif
    end

    // State register.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state <= S_IDLE;
        end else begin
            state <= state_nxt;
        end
    end

    // Next-state logic.
    always_comb begin
        state_nxt = state;
        case (state)
            S_IDLE:  if (start) state_nxt = S_RUN;
            S_RUN:   if (last_iter) state_nxt = S_DONE;
            S_DONE:  state_nxt = S_IDLE;
            default: state_nxt = S_IDLE;
        endcase
    end

    // Datapath: operand capture, one shift-and-add step per RUN cycle,
    // result load on the edge that leaves RUN.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            mcand  <= 32'd0;
            mplier <= 32'd0;
            acc    <= 32'd0;
            cnt    <= 5'd0;
            p      <= 32'd0;
        end else begin
            case (state)
                S_IDLE: begin
                    if (start) begin
                        mcand  <= a;
                        mplier <= b;
                        acc    <= 32'd0;
                        cnt    <= 5'd0;
                    end
                end
                S_RUN: begin
                    acc    <= acc_nxt;
                    mcand  <= {mcand[30:0], 1'b0};
                    mplier <= {1'b0, mplier[31:1]};
                    cnt    <= cnt + 5'd1;
                    if (last_iter) begin
                        p <= acc_nxt;
                    end
                end
                default: begin
                end
            endcase
        end
    end

    // Status outputs decode directly from the state, so they can never overlap.
    assign busy = (state == S_RUN);
    assign done = (state == S_DONE);
endmodule

// File: tb/tb__mul32.sv
// Directed bench for _mul32. Build with +define+MUL32_EARLY_EN to check the
// early-termination timing; expected products are the same in both builds.
module tb__mul32;
    logic        clk = 1'b0;
    logic        rst_n = 1'b1;
    logic        start = 1'b0;
    logic [31:0] a = 32'd0;
    logic [31:0] b = 32'd0;
    logic        busy;
    logic        done;
    logic [31:0] p;

    int n_assert = 0;
    int n_fail   = 0;

    _mul32 dut (
        .clk   (clk),
        .rst_n (rst_n),
        .start (start),
        .a     (a),
        .b     (b),
        .busy  (busy),
        .done  (done),
        .p     (p)
    );

    // Clock generation, 10 time-unit period.
    always #5 clk = ~clk;

    // Number of RUN cycles expected for multiplier bv.
    function automatic int iters(input logic [31:0] bv);
`ifdef MUL32_EARLY_EN
        int n = 1;
        for (int i = 0; i < 32; i++) begin
            if (bv[i]) n = i + 1;
        end
        return n;
`else
        return 32;
`endif
    endfunction

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_assert++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s observed=0x%08h expected=0x%08h", tag, obs, exp);
        end
    endtask

    // Called #1 after the accepting edge (cycle 1). Walks cycles 1..run+1,
    // checking busy/done every cycle, p stable during RUN and p at done.
    // If chg_cyc > 0, a and b are overwritten with 7 in that cycle.
    task automatic run_checks(input string tag, input logic [31:0] exp_p,
                              input int run_n, input int chg_cyc);
        logic [31:0] p_prev;
        p_prev = p;
        for (int c = 1; c <= run_n + 1; c++) begin
            if (c == chg_cyc) begin
                a = 32'd7;
                b = 32'd7;
            end
            chk({tag, " busy"}, {31'd0, busy}, {31'd0, c <= run_n});
            chk({tag, " done"}, {31'd0, done}, {31'd0, c == run_n + 1});
            if (c == run_n + 1) chk({tag, " p"}, p, exp_p);
            else                chk({tag, " p_hold"}, p, p_prev);
            if (c <= run_n) begin
                @(posedge clk);
                #1;
            end
        end
    endtask

    task automatic check_idle(input string tag);
        @(posedge clk);
        #1;
        chk({tag, " idle_busy"}, {31'd0, busy}, 32'd0);
        chk({tag, " idle_done"}, {31'd0, done}, 32'd0);
    endtask

    // Issue one multiply from IDLE and check it to completion.
    task automatic run_op(input string tag, input logic [31:0] av,
                          input logic [31:0] bv, input logic [31:0] exp_p);
        @(negedge clk);
        a     = av;
        b     = bv;
        start = 1'b1;
        @(posedge clk);
        #1;
        start = 1'b0;
        a     = $urandom;
        b     = $urandom;
        run_checks(tag, exp_p, iters(bv), 0);
        check_idle(tag);
    endtask

    initial begin
        int done_seen;

        // Reset: asynchronous, checked before any clock edge.
        #2 rst_n = 1'b0;
        #1;
        chk("rst busy", {31'd0, busy}, 32'd0);
        chk("rst done", {31'd0, done}, 32'd0);
        chk("rst p", p, 32'd0);
        @(negedge clk);
        @(negedge clk);
        rst_n = 1'b1;

        // Basic products and wrap-around.
        run_op("3x5", 32'd3, 32'd5, 32'h0000_000F);
        run_op("ffxff", 32'hFFFF_FFFF, 32'hFFFF_FFFF, 32'h0000_0001);
        run_op("big", 32'h1234_5678, 32'h9ABC_DEF0, 32'h242D_2080);
        run_op("ovf", 32'h0001_0000, 32'h0001_0000, 32'h0000_0000);
        run_op("bone", 32'hDEAD_BEEF, 32'h0000_0001, 32'hDEAD_BEEF);
        run_op("bmsb", 32'h0000_0001, 32'h8000_0000, 32'h8000_0000);
        run_op("bzero", 32'hCAFE_F00D, 32'h0000_0000, 32'h0000_0000);

        // start held high through RUN and DONE, operands changed at cycle 5.
        @(negedge clk);
        a     = 32'd3;
        b     = 32'd5;
        start = 1'b1;
        @(posedge clk);
        #1;
        run_checks("hold1", 32'h0000_000F, iters(32'd5), 5);
        check_idle("hold1");
        // The still-high start is taken at the first IDLE edge with a=b=7.
        @(posedge clk);
        #1;
        start = 1'b0;
        run_checks("hold2", 32'h0000_0031, iters(32'd7), 0);
        check_idle("hold2");

        // Reset in the middle of RUN (multiplier forces 32 iterations).
        @(negedge clk);
        a     = 32'd5;
        b     = 32'h8000_0003;
        start = 1'b1;
        @(posedge clk);
        #1;
        start = 1'b0;
        repeat (9) @(posedge clk);
        #1;
        chk("abort busy_before", {31'd0, busy}, 32'd1);
        #2 rst_n = 1'b0;
        #1;
        chk("abort busy", {31'd0, busy}, 32'd0);
        chk("abort done", {31'd0, done}, 32'd0);
        chk("abort p", p, 32'd0);
        @(negedge clk);
        rst_n = 1'b1;
        done_seen = 0;
        for (int c = 0; c < 40; c++) begin
            @(posedge clk);
            #1;
            if (done || busy) done_seen++;
        end
        chk("abort no_done", done_seen, 32'd0);

        // First start accepted on the first edge after reset release.
        @(negedge clk);
        rst_n = 1'b0;
        @(negedge clk);
        rst_n = 1'b1;
        a     = 32'd6;
        b     = 32'd9;
        start = 1'b1;
        @(posedge clk);
        #1;
        start = 1'b0;
        run_checks("post_rst", 32'd54, iters(32'd9), 0);
        check_idle("post_rst");

        run_op("after", 32'd3, 32'd5, 32'h0000_000F);

        $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
        $finish;
    end
endmodule

// File: doc/_mul32.md
_MUL32 -- requirements
Module: _mul32

Interface
REQ-001 The block SHALL have one clock and an asynchronous, active-low reset.
REQ-002 clk  input  1  rising-edge clock for all state.
REQ-003 rst_n  input  1  asynchronous active-low reset.
REQ-004 start  input  1  request a multiply; sampled only in IDLE.
REQ-005 a  input  32  multiplicand; captured on an accepted start.
REQ-006 b  input  32  multiplier; captured on an accepted start.
REQ-007 busy  output  1  high while in RUN.
REQ-008 done  output  1  one-cycle pulse when p is valid.
REQ-009 p  output  32  low 32 bits of a*b (RV32 MUL semantics, sign-agnostic).

Function
REQ-010 Three states SHALL exist, with transitions as follows.
- IDLE: start=1 goes to RUN; otherwise stay in IDLE.
- RUN: iterate; exit to DONE per REQ-013 or REQ-027.
- DONE: always goes to IDLE after one cycle.
REQ-011 On an accepted start (IDLE, start=1 at an edge), the block SHALL load the following registers.
- mcand=a
- mplier=b
- acc=0
- cnt=0
REQ-012 Each RUN cycle SHALL perform one iteration, all updates at the same edge.
- If mplier[0]=1: acc <= acc+mcand (mod 2^32).
- mcand <<= 1, zero fill.
- mplier >>= 1, zero fill.
- cnt += 1.
REQ-013 RUN SHALL end after the iteration with cnt=31, i.e. exactly 32 iterations.
REQ-014 The acc+mcand addition SHALL be made by one instance of the team's 32-bit ripple adder (carry-in 0, no carry-out); no other adder is permitted.
REQ-015 On the edge leaving RUN, p SHALL load the final acc; in DONE, done=1 for exactly one cycle.
REQ-016 p SHALL hold its value from that load until the next load; it SHALL NOT change during RUN.
REQ-017 Latency without the REQ-027 macro: start accepted at edge 0; busy=1 during cycles 1..32; done=1 during cycle 33; p valid from cycle 33.
REQ-018 start SHALL be ignored in RUN and DONE.
- No restart occurs and no operand is recaptured.
- A start held high through DONE is accepted at the first edge in IDLE.
REQ-019 a and b SHALL be don't-care after capture; changing them mid-operation SHALL NOT affect the result.
REQ-020 Overflow beyond bit 31 SHALL be discarded silently; no flag is raised.
REQ-021 busy and done SHALL never be high in the same cycle.

Reset
REQ-022 When rst_n=0, the block SHALL go to IDLE immediately, regardless of clk.
REQ-023 Reset values SHALL be as follows.
- busy=0, done=0, p=0.
- acc=0, mcand=0, mplier=0, cnt=0.
REQ-024 Reset asserted mid-RUN SHALL abort the operation; no done pulse follows, and p reads 0.
REQ-025 After rst_n deasserts, the first start SHALL be accepted at the first rising edge where rst_n=1.

Configuration
REQ-026 The macro MUL32_EARLY_EN SHALL select the termination rule; it is the only compile-time option.
REQ-027 With MUL32_EARLY_EN defined, RUN SHALL also end after any iteration whose updated mplier is zero.
- At least one iteration always runs; at most 32.
- b=0 or b=1 gives one RUN cycle, with done in cycle 2.
- The p value SHALL be identical to the value without the macro.
REQ-028 Without MUL32_EARLY_EN, the fixed 32-iteration timing of REQ-017 SHALL apply for every operand.

Verification
REQ-029 a=3, b=5, start at edge 0 -> busy cycles 1..32; done in cycle 33 only; p=0x0000000F.
REQ-030 a=0xFFFFFFFF, b=0xFFFFFFFF -> p=0x00000001; a=0x12345678, b=0x9ABCDEF0 -> p=0x242D2080.
REQ-031 start held high during RUN and DONE, with a and b changed to 7 and 7 at cycle 5 -> first result is unchanged (3*5=0x0F); a second operation starts from the first IDLE edge and gives p=0x31.
REQ-032 rst_n low at cycle 10 of a RUN -> busy=0, done=0, p=0 at once; no done pulse follows; the next start computes correctly.
REQ-033 With MUL32_EARLY_EN: b=1, a=0xDEADBEEF -> done in cycle 2, p=0xDEADBEEF; b=0x80000000, a=1 -> done in cycle 33, p=0x80000000; b=0 -> done in cycle 2, p=0.
